display_timing_480p: RTL
========================

Name: display_timing_480p

Overview:
- Generates 640x480@60 Hz raster timing on the pixel clock.
- Drives sx/sy into the pattern painter and produces hsync, vsync and data-enable for the HDMI/DVI encoder.
- Sync and enable are delayed by a configurable pipeline depth so they line up with the painter's registered RGB output.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level; 0 = active-low
- PIPE_DLY, 1, cycles of delay on hsync/vsync/de; legal range 1..4

Ports:
- clk_pix  in  1  pixel clock, 25.2 MHz nominal
- rst_pix  in  1  reset, asynchronous, active-high
- sx  out  10  horizontal counter, 0..H_TOTAL-1
- sy  out  10  vertical counter, 0..V_TOTAL-1
- line  out  1  high while sx==0
- frame  out  1  high while sx==0 and sy==0
- hsync  out  1  horizontal sync, delayed by PIPE_DLY
- vsync  out  1  vertical sync, delayed by PIPE_DLY
- de  out  1  active video enable, delayed by PIPE_DLY
- frame_cnt  out  16  completed-frame counter

Behaviour:
- One clock domain: clk_pix. Reset is asynchronous and active-high on rst_pix.
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525
- Reset values:
  - sx=0, sy=0, frame_cnt=0
  - every stage of the hsync/vsync delay line at the deasserted level (~SYNC_POL); de stages =0
  - line and frame therefore read 1 immediately after reset release.
- Counters, updated every clk_pix edge:
  - sx increments by 1; at sx==H_TOTAL-1 it wraps to 0.
  - sy advances only on the sx wrap; at sy==V_TOTAL-1 it wraps to 0 in the same cycle sx wraps.
- frame_cnt:
  - increments by 1 on the cycle where both sx and sy wrap.
  - wraps modulo 2^16 (0xFFFF -> 0x0000).
- line and frame are combinational decodes of the sx/sy registers, with zero latency relative to sx/sy.
- Undelayed raster decodes:
  - de_raw = (sx < H_ACTIVE) && (sy < V_ACTIVE)
  - hs_raw asserted for H_ACTIVE+H_FP <= sx < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs_raw asserted for V_ACTIVE+V_FP <= sy < V_ACTIVE+V_FP+V_SYNC (490..491), over the full width of those lines
  - asserted level = SYNC_POL
- Output alignment:
  - hsync/vsync/de equal hs_raw/vs_raw/de_raw from PIPE_DLY cycles earlier.
  - With PIPE_DLY=1, de rises on the same edge the painter registers RGB for (sx,sy)=(0,0).
- Boundary conditions:
  - Reset mid-frame: counters return to (0,0) asynchronously; the delay lines flush to inactive levels. No partial sync pulse is emitted after reset release until the raster reaches the sync region again.
  - No enable input: the raster free-runs.
- Elaboration checks:
  - PIPE_DLY outside 1..4 is an elaboration error.
  - H_TOTAL or V_TOTAL exceeding 1024 is an elaboration error, since they must fit 10 bits.

Decomposition:
- Package display_pkg holds:
  - the 480p timing localparams and derived H_TOTAL/V_TOTAL
  - typedef coord_t (logic [9:0])
  - SYNC_POL default
- The painter and this block share display_pkg.
- One sub-module, sig_delay, is natural: a WIDTH-bit, DEPTH-stage shift register with async-high reset to a parameterised RESET_VAL. It is instantiated once with WIDTH=3 for {hsync, vsync, de}.

Test Plan:
- Reset then release, PIPE_DLY=1, SYNC_POL=0:
  - cycle 0: sx=0, sy=0, frame=1, line=1, hsync=1, vsync=1, de=0
  - cycle 1: de=1
- Run one line from (0,0):
  - sx reaches 799 then returns to 0 with sy=1.
  - de is high for exactly 640 cycles.
  - hsync is low for exactly 96 cycles, going low 657 cycles after line start.
- Run one full frame (420000 cycles):
  - vsync is low for exactly 1600 cycles (lines 490-491).
  - frame_cnt goes 0->1 on the edge where sx=0, sy=0 recurs.
  - frame pulses once per frame.
- Preload frame_cnt path by running 65536 frames (fast-forward via force allowed): frame_cnt wraps 0xFFFF->0x0000.
- Assert rst_pix asynchronously at sx=700, sy=100 (inside hsync):
  - hsync, vsync and de go inactive immediately.
  - sx=0, sy=0 with no clock edge required.
- PIPE_DLY=3: hsync/vsync/de transitions lag the PIPE_DLY=1 build by exactly 2 cycles, with identical widths.

Source files
------------

// File: rtl/display_pkg.sv
// Shared 640x480@60 Hz timing constants for the raster generator and the
// pattern painter. Derived totals must fit a 10-bit coordinate.
package display_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

    // Asserted level of hsync/vsync; 0 = active-low (standard for 480p).
    localparam logic SYNC_POL = 1'b0;

    typedef logic [9:0] coord_t;

endpackage

// File: rtl/sig_delay.sv
// WIDTH-bit, DEPTH-stage shift register with asynchronous active-high reset
// of every stage to RESET_VAL.
//   clk  : clock
//   rst  : async reset, active-high
//   din  : input word, sampled every edge
//   dout : din delayed by DEPTH cycles
module sig_delay #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
    logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_q <= {DEPTH{RESET_VAL}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/display_timing_480p.sv
// 640x480@60 Hz raster timing generator on the pixel clock.
//   clk_pix   : pixel clock (25.2 MHz nominal)
//   rst_pix   : async reset, active-high
//   sx, sy    : raster position, feeds the pattern painter
//   line      : sx==0 (combinational, same cycle as sx/sy)
//   frame     : sx==0 && sy==0 (combinational)
//   hsync     : horizontal sync, PIPE_DLY cycles behind sx/sy
//   vsync     : vertical sync, PIPE_DLY cycles behind sx/sy
//   de        : active video enable, PIPE_DLY cycles behind sx/sy
//   frame_cnt : completed-frame counter, wraps modulo 2^16
// hsync/vsync/de are delayed so they line up with the painter's registered
// RGB; sx/sy/line/frame are not delayed.
module display_timing_480p #(
    parameter int   H_ACTIVE = display_pkg::H_ACTIVE,
    parameter int   H_FP     = display_pkg::H_FP,
    parameter int   H_SYNC   = display_pkg::H_SYNC,
    parameter int   H_BP     = display_pkg::H_BP,
    parameter int   V_ACTIVE = display_pkg::V_ACTIVE,
    parameter int   V_FP     = display_pkg::V_FP,
    parameter int   V_SYNC   = display_pkg::V_SYNC,
    parameter int   V_BP     = display_pkg::V_BP,
    parameter logic SYNC_POL = display_pkg::SYNC_POL,
    parameter int   PIPE_DLY = 1
) (
    input  logic        clk_pix,
    input  logic        rst_pix,
    output logic [9:0]  sx,
    output logic [9:0]  sy,
    output logic        line,
    output logic        frame,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] frame_cnt
);

    import display_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_pipe_dly
        $error("display_timing_480p: PIPE_DLY must be in 1..4");
    end
    if (H_TOT > 1024 || V_TOT > 1024) begin : g_bad_total
        $error("display_timing_480p: H_TOTAL/V_TOTAL must fit 10 bits");
    end

    localparam coord_t H_LAST = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);

    // Region bounds kept 11 bits wide so an end bound equal to 1024 still
    // compares correctly against a zero-extended 10-bit coordinate.
    localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    coord_t      sx_q, sx_d;
    coord_t      sy_q, sy_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        h_end, v_end;
    logic        hs_raw, vs_raw, de_raw;
    logic [10:0] sx_e, sy_e;

    always_comb begin
        h_end       = (sx_q == H_LAST);
        v_end       = (sy_q == V_LAST);
        sx_d        = h_end ? '0 : sx_q + 10'd1;
        sy_d        = sy_q;
        if (h_end) begin
            sy_d = v_end ? '0 : sy_q + 10'd1;
        end
        frame_cnt_d = frame_cnt_q + {15'd0, h_end && v_end};
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            sx_q        <= '0;
            sy_q        <= '0;
            frame_cnt_q <= '0;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        sx_e   = {1'b0, sx_q};
        sy_e   = {1'b0, sy_q};
        de_raw = (sx_e < H_ACT_E) && (sy_e < V_ACT_E);
        hs_raw = ((sx_e >= HS_BEG) && (sx_e < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_raw = ((sy_e >= VS_BEG) && (sy_e < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Reset flushes every stage to the inactive levels, so no partial sync
    // pulse can escape after reset release.
    sig_delay #(
        .WIDTH     (3),
        .DEPTH     (PIPE_DLY),
        .RESET_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_sync_dly (
        .clk  (clk_pix),
        .rst  (rst_pix),
        .din  ({hs_raw, vs_raw, de_raw}),
        .dout ({hsync, vsync, de})
    );

    assign sx        = sx_q;
    assign sy        = sy_q;
    assign line      = (sx_q == '0);
    assign frame     = (sx_q == '0) && (sy_q == '0);
    assign frame_cnt = frame_cnt_q;

endmodule
